wash_cycle_scheduler: RTL and testbench

- Sequences one full wash cycle: Idle -> Wash_fill -> Wash_agitate -> Wash_spin -> Rinse_fill -> Rinse_agitate -> Rinse_spin -> Idle.
- Replaces free-running one-phase-per-clock stepping with phase durations counted on a timebase strobe and fill completion taken from a level sensor.
- Drives the phase code, hot/cold valves, motor mode and door lock.
- Pauses on a door-open event and faults on a fill timeout.

---
 rtl/wm_pkg.sv | 27 ++
 rtl/phase_timer.sv | 32 +++
 rtl/wash_cycle_scheduler.sv | 145 ++++++++++++++
 tb/tb_wash_cycle_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared phase, valve and motor encodings for the wash cycle scheduler.
package wm_pkg;

    typedef enum logic [2:0] {
        PH_OFF   = 3'd0,
        PH_IDLE  = 3'd1,
        PH_WFILL = 3'd2,
        PH_WAGIT = 3'd3,
        PH_WSPIN = 3'd4,
        PH_RFILL = 3'd5,
        PH_RAGIT = 3'd6,
        PH_RSPIN = 3'd7
    } phase_e;

    localparam logic [1:0] W_OFF  = 2'b00;
    localparam logic [1:0] W_HOT  = 2'b10;
    localparam logic [1:0] W_COLD = 2'b01;

    localparam logic [1:0] M_OFF  = 2'b00;
    localparam logic [1:0] M_AGIT = 2'b01;
    localparam logic [1:0] M_SPIN = 2'b10;

    function automatic logic is_busy(input phase_e p);
        return (p >= PH_WFILL);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick counter for one phase; expire flags the tick that completes the limit.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = enable && (cnt_q == (limit - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wash_cycle_scheduler.sv
// Wash cycle sequencer: tick-timed phases, level-sensed fills, door pause, fill-timeout fault.
module wash_cycle_scheduler
    import wm_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int AGITATE_TICKS = 20,
    parameter int SPIN_TICKS    = 10,
    parameter int FILL_TIMEOUT  = 50
) (
    input  logic       clkorig,
    input  logic       power,
    input  logic       start,
    input  logic       door,
    input  logic       tick,
    input  logic       level_full,
    output logic [2:0] phase,
    output logic [1:0] water,
    output logic [1:0] motor,
    output logic       door_lock,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    phase_e phase_q, phase_d;
    logic   paused_q, paused_d;
    logic   fault_q, fault_d;
    logic   done_q, done_d;

    logic             hold;
    logic             t_clear, t_en, t_exp;
    logic [CNT_W-1:0] t_limit;

    assign busy      = is_busy(phase_q);
    assign door_lock = busy;
    assign phase     = phase_q;
    assign done      = done_q;
    assign fault     = fault_q;

    // A door opening freezes timing in the same cycle, before paused_q registers it.
    assign hold = busy && (door || paused_q);
    assign t_en = tick && !hold;

    always_comb begin
        t_limit = CNT_W'(1);
        case (phase_q)
            PH_WFILL, PH_RFILL: t_limit = CNT_W'(FILL_TIMEOUT);
            PH_WAGIT, PH_RAGIT: t_limit = CNT_W'(AGITATE_TICKS);
            PH_WSPIN, PH_RSPIN: t_limit = CNT_W'(SPIN_TICKS);
            default:            t_limit = CNT_W'(1);
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clkorig),
        .rst_n  (power),
        .clear  (t_clear),
        .enable (t_en),
        .limit  (t_limit),
        .expire (t_exp)
    );

    always_comb begin
        phase_d  = phase_q;
        fault_d  = fault_q;
        done_d   = 1'b0;
        paused_d = busy && door;
        t_clear  = 1'b0;
        case (phase_q)
            PH_OFF: begin
                phase_d = PH_IDLE;
                t_clear = 1'b1;
            end
            PH_IDLE: begin
                t_clear = 1'b1;
                if (start && !door) begin
                    phase_d = PH_WFILL;
                    fault_d = 1'b0;
                end
            end
            PH_WFILL, PH_RFILL: begin
                if (!hold && level_full) begin
                    phase_d = (phase_q == PH_WFILL) ? PH_WAGIT : PH_RAGIT;
                    t_clear = 1'b1;
                end else if (t_exp) begin
                    phase_d = PH_IDLE;
                    fault_d = 1'b1;
                    t_clear = 1'b1;
                end
            end
            PH_WAGIT, PH_RAGIT: begin
                if (t_exp) begin
                    phase_d = (phase_q == PH_WAGIT) ? PH_WSPIN : PH_RSPIN;
                    t_clear = 1'b1;
                end
            end
            PH_WSPIN: begin
                if (t_exp) begin
                    phase_d = PH_RFILL;
                    t_clear = 1'b1;
                end
            end
            PH_RSPIN: begin
                if (t_exp) begin
                    phase_d = PH_IDLE;
                    done_d  = 1'b1;
                    t_clear = 1'b1;
                end
            end
            default: phase_d = PH_OFF;
        endcase
    end

    always_ff @(posedge clkorig) begin
        if (!power) begin
            phase_q  <= PH_OFF;
            paused_q <= 1'b0;
            fault_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            paused_q <= paused_d;
            fault_q  <= fault_d;
            done_q   <= done_d;
        end
    end

    // Valves and motor are shut off whenever the cycle is paused.
    always_comb begin
        water = W_OFF;
        motor = M_OFF;
        if (!paused_q) begin
            case (phase_q)
                PH_WFILL: water = W_HOT;
                PH_WAGIT: begin water = W_HOT;  motor = M_AGIT; end
                PH_WSPIN: motor = M_SPIN;
                PH_RFILL: water = W_COLD;
                PH_RAGIT: begin water = W_COLD; motor = M_AGIT; end
                PH_RSPIN: motor = M_SPIN;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_wash_cycle_scheduler.sv
// Scoreboard bench: a tick-counting reference model predicts every cycle's outputs.
module tb_wash_cycle_scheduler;

    localparam int AG = 3;
    localparam int SP = 2;
    localparam int FT = 4;

    logic       clkorig = 1'b0;
    logic       power = 1'b0, start = 1'b0, door = 1'b0, tick = 1'b0, level_full = 1'b0;
    logic [2:0] phase;
    logic [1:0] water, motor;
    logic       door_lock, busy, done, fault;

    wash_cycle_scheduler #(.CNT_W(8), .AGITATE_TICKS(AG), .SPIN_TICKS(SP), .FILL_TIMEOUT(FT)) dut (
        .clkorig(clkorig), .power(power), .start(start), .door(door), .tick(tick),
        .level_full(level_full), .phase(phase), .water(water), .motor(motor),
        .door_lock(door_lock), .busy(busy), .done(done), .fault(fault)
    );

    always #5 clkorig = ~clkorig;

    typedef struct packed {
        logic [2:0] ph;
        logic [1:0] w;
        logic [1:0] m;
        logic       lk;
        logic       bz;
        logic       dn;
        logic       ft;
    } exp_t;

    exp_t q[$];
    int   nchk = 0, nerr = 0;
    int   cyc = 0;
    bit   rnd_tick = 0;
    bit   stim_done = 0;

    // Reference model: phase number, ticks elapsed in the phase, pause/fault/done flags.
    int m_phase = 0, m_ticks = 0;
    bit m_paused = 0, m_fault = 0, m_done = 0;

    task automatic model_step(input bit p, s, d, l, t);
        bit bsy, frozen;
        bsy = (m_phase >= 2);
        frozen = bsy && (d || m_paused);
        if (!p) begin
            m_phase = 0; m_ticks = 0; m_fault = 0; m_paused = 0; m_done = 0;
        end else begin
            m_done = 0;
            m_paused = bsy && d;
            if (m_phase == 0) m_phase = 1;
            else if (m_phase == 1) begin
                if (s && !d) begin m_phase = 2; m_ticks = 0; m_fault = 0; end
            end else if (!frozen) begin
                if ((m_phase == 2 || m_phase == 5) && l) begin
                    m_phase = m_phase + 1; m_ticks = 0;
                end else if (t) begin
                    m_ticks = m_ticks + 1;
                    if ((m_phase == 2 || m_phase == 5) && m_ticks == FT) begin
                        m_phase = 1; m_ticks = 0; m_fault = 1;
                    end else if ((m_phase == 3 || m_phase == 6) && m_ticks == AG) begin
                        m_phase = m_phase + 1; m_ticks = 0;
                    end else if ((m_phase == 4 || m_phase == 7) && m_ticks == SP) begin
                        m_done = (m_phase == 7);
                        m_phase = (m_phase == 4) ? 5 : 1; m_ticks = 0;
                    end
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.ph = 3'(m_phase);
        e.bz = (m_phase >= 2);
        e.lk = e.bz;
        e.dn = m_done;
        e.ft = m_fault;
        e.w  = 2'b00;
        e.m  = 2'b00;
        if (!m_paused) begin
            if (m_phase == 2 || m_phase == 3) e.w = 2'b10;
            if (m_phase == 5 || m_phase == 6) e.w = 2'b01;
            if (m_phase == 3 || m_phase == 6) e.m = 2'b01;
            if (m_phase == 4 || m_phase == 7) e.m = 2'b10;
        end
        return e;
    endfunction

    task automatic drive(input bit p, s, d, l);
        bit t;
        t = rnd_tick ? ($urandom_range(0, 2) == 0) : (cyc % 4 == 3);
        power = p; start = s; door = d; level_full = l; tick = t;
        @(posedge clkorig);
        model_step(p, s, d, l, t);
        q.push_back(model_out());
        cyc++;
        #1;
    endtask

    task automatic reach(input string name, input bit ok);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL reach_%s: condition not reached within cycle budget (phase=%0d ticks=%0d)", name, m_phase, m_ticks);
        end
    endtask

    // Monitor: pops one expected record per cycle and compares on the falling edge.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clkorig);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{ph: phase, w: water, m: motor, lk: door_lock, bz: busy, dn: done, ft: fault};
                nchk++;
                if (a !== e) begin
                    nerr++;
                    $display("FAIL outputs cyc=%0d: got ph=%0d w=%b m=%b lk=%b bz=%b dn=%b ft=%b, want ph=%0d w=%b m=%b lk=%b bz=%b dn=%b ft=%b",
                             cyc, a.ph, a.w, a.m, a.lk, a.bz, a.dn, a.ft, e.ph, e.w, e.m, e.lk, e.bz, e.dn, e.ft);
                end
            end
        end
    end

    initial begin
        int n;
        // Reset, then a normal cycle with the tub reporting full immediately.
        repeat (3) drive(0, 0, 0, 0);
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 1);
        drive(1, 1, 0, 1);
        repeat (70) drive(1, 0, 0, 1);
        reach("normal_idle", m_phase == 1);

        // Fill timeout, then a new start clears the fault.
        drive(1, 1, 0, 0);
        repeat (25) drive(1, 0, 0, 0);
        reach("fault_set", m_fault && m_phase == 1);
        drive(1, 1, 0, 1);
        repeat (70) drive(1, 0, 0, 1);

        // Door open for 10 cycles after the first agitate tick.
        drive(1, 1, 0, 1);
        n = 0;
        while (n < 100 && !(m_phase == 3 && m_ticks == 1)) begin drive(1, 0, 0, 1); n++; end
        reach("agit_tick1", m_phase == 3 && m_ticks == 1);
        repeat (10) drive(1, 0, 1, 1);
        repeat (60) drive(1, 0, 0, 1);

        // Start while door open in Idle is ignored.
        n = 0;
        while (n < 100 && m_phase != 1) begin drive(1, 0, 0, 1); n++; end
        reach("idle_before_door_start", m_phase == 1);
        repeat (3) drive(1, 1, 1, 0);
        drive(1, 0, 0, 0);

        // Power drop during rinse agitate.
        drive(1, 1, 0, 1);
        n = 0;
        while (n < 100 && m_phase != 6) begin drive(1, 0, 0, 1); n++; end
        reach("rinse_agit", m_phase == 6);
        drive(0, 0, 0, 1);
        repeat (3) drive(1, 0, 0, 1);

        // Door coincident with the final spin tick blocks that advance.
        drive(1, 1, 0, 1);
        n = 0;
        while (n < 100 && !(m_phase == 4 && m_ticks == SP - 1 && cyc % 4 == 3)) begin drive(1, 0, 0, 1); n++; end
        reach("wash_spin_last", m_phase == 4 && m_ticks == SP - 1);
        drive(1, 0, 1, 1);
        reach("spin_held", m_phase == 4);
        repeat (60) drive(1, 0, 0, 1);

        // Randomized traffic with irregular ticks.
        rnd_tick = 1;
        begin
            bit d;
            d = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 24) == 0) d = ~d;
                drive($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0, d, $urandom_range(0, 5) == 0);
            end
        end
        @(negedge clkorig);
        @(negedge clkorig);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
